// File: rtl/trig_pkg.sv
// Shared types and constants for the iterative trig series unit: FSM state
// encoding, term-count bound, and the elaboration-time coefficient generator.
package trig_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SQR    = 3'd1,
        MUL_X2 = 3'd2,
        MUL_C  = 3'd3,
        ACC    = 3'd4,
        DONE   = 3'd5
    } trig_state_e;

    localparam int MAX_TERMS = 8;

    // Extra integer headroom on the term path: x^(2k+2)/(2k)! peaks near 170
    // as x approaches 4, before the coefficient multiply pulls it back down.
    localparam int TERM_HEAD_W = 4;

    // Reciprocal coefficient for iteration k, floor-quantised to Q0.coef_w.
    function automatic int unsigned trig_coef(input int k, input bit sin_mode, input int coef_w);
        int unsigned den;
        if (sin_mode) begin
            den = (2 * k + 2) * (2 * k + 3);
        end else begin
            den = (2 * k + 1) * (2 * k + 2);
        end
        return (32'd1 << coef_w) / den;
    endfunction

endpackage

// File: rtl/fxp_mul_trunc.sv
// Signed x signed fixed-point multiply; the product is shifted right by SHIFT
// with floor semantics (arithmetic shift) and truncated back to A_W bits.
module fxp_mul_trunc #(
    parameter int A_W   = 18,
    parameter int B_W   = 22,
    parameter int SHIFT = 12
) (
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [A_W-1:0] p
);

    logic signed [A_W+B_W-1:0] full;

    assign full = a * b;
    assign p    = A_W'(full >>> SHIFT);

endmodule

// File: rtl/trig_series_unit.sv
// Iterative fixed-point cosine (optionally sine) over an N-term Maclaurin series,
// one shared multiplier. Define TRIG_SIN_MODE_EN to add the mode port and sine table.
module trig_series_unit
    import trig_pkg::*;
#(
    parameter int FRAC_W  = 8,
    parameter int N_TERMS = 4,
    parameter int COEF_W  = 12,
    parameter int GUARD_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FRAC_W+1:0] x,
`ifdef TRIG_SIN_MODE_EN
    input  logic              mode,
`endif
    output logic              busy,
    output logic              done,
    output logic [1:0]        intpart,
    output logic [FRAC_W-1:0] fracpart,
    output logic [2:0]        dbg_state
);

    localparam int DW    = GUARD_W + TERM_HEAD_W + FRAC_W;
    localparam int BW    = DW - FRAC_W + COEF_W;
    localparam int OUT_W = FRAC_W + 2;
    localparam int KW    = $clog2(MAX_TERMS);

    localparam logic signed [DW-1:0] ONE_FX = DW'(1) << FRAC_W;
    localparam logic signed [DW-1:0] SAT_HI = DW'((1 << (FRAC_W + 1)) - 1);
    localparam logic signed [DW-1:0] SAT_LO = ~SAT_HI;

    // Handshake: a launch happens on a clock edge where the unit is IDLE, start
    // is 1 and armed is set; armed is set by any edge seeing start==0, so a
    // start level held high runs exactly one operation. done pulses for one
    // cycle in DONE with the new result already on intpart/fracpart.

    trig_state_e             state_q, state_d;
    logic                    armed_q, armed_d;
    logic [OUT_W-1:0]        x_q, x_d;
    logic signed [DW-1:0]    x2_q, x2_d;
    logic signed [DW-1:0]    term_q, term_d;
    logic signed [DW-1:0]    acc_q, acc_d;
    logic [KW-1:0]           k_q, k_d;
    logic [OUT_W-1:0]        res_q, res_d;
`ifdef TRIG_SIN_MODE_EN
    logic                    sin_q, sin_d;
    logic [COEF_W-1:0]       sin_tab [MAX_TERMS];
`endif

    logic [COEF_W-1:0]       cos_tab [MAX_TERMS];
    logic [COEF_W-1:0]       coef_sel;
    logic signed [DW-1:0]    term_init;
    logic signed [DW-1:0]    mul_a, mul_p;
    logic signed [BW-1:0]    mul_b;

    always_comb begin
        for (int i = 0; i < MAX_TERMS; i++) begin
            cos_tab[i] = COEF_W'(trig_coef(i, 1'b0, COEF_W));
        end
    end

`ifdef TRIG_SIN_MODE_EN
    always_comb begin
        for (int i = 0; i < MAX_TERMS; i++) begin
            sin_tab[i] = COEF_W'(trig_coef(i, 1'b1, COEF_W));
        end
    end

    assign coef_sel  = sin_q ? sin_tab[k_q] : cos_tab[k_q];
    assign term_init = mode ? DW'(x) : ONE_FX;
`else
    assign coef_sel  = cos_tab[k_q];
    assign term_init = ONE_FX;
`endif

    // Operand steering for the single multiplier. The b port carries COEF_W
    // fraction bits, so Q.FRAC_W operands are left-aligned into it exactly.
    always_comb begin
        mul_a = term_q;
        mul_b = BW'(x2_q) <<< (COEF_W - FRAC_W);
        case (state_q)
            SQR: begin
                mul_a = DW'(x_q);
                mul_b = BW'(x_q) << (COEF_W - FRAC_W);
            end
            MUL_C: begin
                mul_b = BW'(coef_sel);
            end
            default: begin
            end
        endcase
    end

    fxp_mul_trunc #(
        .A_W  (DW),
        .B_W  (BW),
        .SHIFT(COEF_W)
    ) u_mul (
        .a(mul_a),
        .b(mul_b),
        .p(mul_p)
    );

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        x_d     = x_q;
        x2_d    = x2_q;
        term_d  = term_q;
        acc_d   = acc_q;
        k_d     = k_q;
        res_d   = res_q;
`ifdef TRIG_SIN_MODE_EN
        sin_d   = sin_q;
`endif
        if (!start) begin
            armed_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start && armed_q) begin
                    armed_d = 1'b0;
                    state_d = SQR;
                    x_d     = x;
                    k_d     = '0;
                    term_d  = term_init;
                    acc_d   = term_init;
`ifdef TRIG_SIN_MODE_EN
                    sin_d   = mode;
`endif
                end
            end
            SQR: begin
                x2_d    = mul_p;
                state_d = MUL_X2;
            end
            MUL_X2: begin
                term_d  = mul_p;
                state_d = MUL_C;
            end
            MUL_C: begin
                // Series alternates sign: even k subtracts, odd k adds.
                term_d  = mul_p;
                acc_d   = k_q[0] ? (acc_q + mul_p) : (acc_q - mul_p);
                k_d     = k_q + 1'b1;
                state_d = ACC;
            end
            ACC: begin
                if (32'(k_q) < N_TERMS - 1) begin
                    state_d = MUL_X2;
                end else begin
                    state_d = DONE;
                    if (acc_q > SAT_HI) begin
                        res_d = SAT_HI[OUT_W-1:0];
                    end else if (acc_q < SAT_LO) begin
                        res_d = SAT_LO[OUT_W-1:0];
                    end else begin
                        res_d = acc_q[OUT_W-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            x_q     <= '0;
            x2_q    <= '0;
            term_q  <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            res_q   <= '0;
`ifdef TRIG_SIN_MODE_EN
            sin_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            x_q     <= x_d;
            x2_q    <= x2_d;
            term_q  <= term_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            res_q   <= res_d;
`ifdef TRIG_SIN_MODE_EN
            sin_q   <= sin_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign intpart   = res_q[OUT_W-1:FRAC_W];
    assign fracpart  = res_q[FRAC_W-1:0];
    assign dbg_state = state_q;

endmodule
